cam_index_decoder: RTL and testbench

- Binary-to-one-hot decoder for the CAM write/erase path; the inverse of the CAM match priority encoder.
- Takes an encoded entry index over a valid/ready handshake and produces a registered, single-cycle one-hot write-enable vector for the CAM entry array.
- Contains a sweep sequencer that walks every entry one per cycle for clear-all and initialisation.
- Sits between the CAM controller and the entry array.

---
 rtl/cam_index_decoder.sv | 125 ++++++++++++
 tb/tb_cam_index_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cam_index_decoder.sv
// Binary-to-one-hot write-enable decoder for the CAM entry array, with a
// clear-all sweep sequencer that walks every entry once, one per cycle.
module cam_index_decoder #(
  parameter int    WIDTH     = 4,
  parameter string SWEEP_DIR = "UP"
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] index_in,
  input  logic                                   index_valid,
  output logic                                   index_ready,
  input  logic                                   sweep_start,
  output logic [WIDTH-1:0]                       output_decoded,
  output logic                                   output_valid,
  output logic                                   index_error,
  output logic                                   busy,
  output logic                                   sweep_done
);

  localparam int             IW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam bit             DOWN      = (SWEEP_DIR == "DOWN");
  localparam logic [IW-1:0]  FIRST_IDX = IW'(DOWN ? WIDTH - 1 : 0);
  localparam logic [IW-1:0]  LAST_IDX  = IW'(DOWN ? 0 : WIDTH - 1);
  // One extra bit so WIDTH itself is representable when range-checking index_in.
  localparam logic [IW:0]    WIDTH_X   = (IW + 1)'(WIDTH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dec_q, dec_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             accept;
  logic             idx_ok;

  function automatic logic [WIDTH-1:0] onehot(input logic [IW-1:0] idx);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx == IW'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [IW-1:0] step(input logic [IW-1:0] idx);
    return DOWN ? (idx - IW'(1)) : (idx + IW'(1));
  endfunction

  assign busy        = (state_q == S_SWEEP);
  assign index_ready = ~busy & ~sweep_start;
  assign accept      = index_valid & index_ready;
  assign idx_ok      = ({1'b0, index_in} < WIDTH_X);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_d   = '0;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sweep_start) begin
          state_d = S_SWEEP;
          cnt_d   = FIRST_IDX;
          dec_d   = onehot(FIRST_IDX);
          vld_d   = 1'b1;
          done_d  = (FIRST_IDX == LAST_IDX);
        end else if (accept) begin
          if (idx_ok) begin
            dec_d = onehot(index_in);
            vld_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SWEEP: begin
        // cnt_q is the entry on the output this cycle; leave once the last has shown.
        if (cnt_q == LAST_IDX) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d  = step(cnt_q);
          dec_d  = onehot(cnt_d);
          vld_d  = 1'b1;
          done_d = (cnt_d == LAST_IDX);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dec_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign output_decoded = dec_q;
  assign output_valid   = vld_q;
  assign index_error    = err_q;
  assign sweep_done     = done_q;

endmodule

// File: tb/tb_cam_index_decoder.sv
// Scoreboard bench: four decoder configurations share one stimulus stream and
// are compared each cycle against a queue-based behavioural model.
module tb_cam_index_decoder;

  localparam int K = 4;
  localparam int W   [K] = '{4, 4, 6, 1};
  localparam int DN  [K] = '{0, 1, 0, 0};
  localparam int IWK [K] = '{2, 2, 3, 1};

  logic       clk;
  logic       rst;
  logic       sweep_start;
  logic       index_valid;
  logic [2:0] idx3;

  logic [3:0] dec0, dec1;
  logic [5:0] dec2;
  logic [0:0] dec3;
  logic [K-1:0] rdy, vld, err, bsy, dn;

  cam_index_decoder #(.WIDTH(4), .SWEEP_DIR("UP")) u_w4up (
    .clk(clk), .rst(rst), .index_in(idx3[1:0]), .index_valid(index_valid),
    .index_ready(rdy[0]), .sweep_start(sweep_start), .output_decoded(dec0),
    .output_valid(vld[0]), .index_error(err[0]), .busy(bsy[0]), .sweep_done(dn[0]));

  cam_index_decoder #(.WIDTH(4), .SWEEP_DIR("DOWN")) u_w4dn (
    .clk(clk), .rst(rst), .index_in(idx3[1:0]), .index_valid(index_valid),
    .index_ready(rdy[1]), .sweep_start(sweep_start), .output_decoded(dec1),
    .output_valid(vld[1]), .index_error(err[1]), .busy(bsy[1]), .sweep_done(dn[1]));

  cam_index_decoder #(.WIDTH(6), .SWEEP_DIR("UP")) u_w6up (
    .clk(clk), .rst(rst), .index_in(idx3), .index_valid(index_valid),
    .index_ready(rdy[2]), .sweep_start(sweep_start), .output_decoded(dec2),
    .output_valid(vld[2]), .index_error(err[2]), .busy(bsy[2]), .sweep_done(dn[2]));

  cam_index_decoder #(.WIDTH(1), .SWEEP_DIR("UP")) u_w1up (
    .clk(clk), .rst(rst), .index_in(idx3[0:0]), .index_valid(index_valid),
    .index_ready(rdy[3]), .sweep_start(sweep_start), .output_decoded(dec3),
    .output_valid(vld[3]), .index_error(err[3]), .busy(bsy[3]), .sweep_done(dn[3]));

  typedef struct {
    bit         chk;
    logic [5:0] dec;
    logic       vld, err, busy, done, rdy;
  } exp_t;

  exp_t       sbq [K][$];
  int         swp [K][$];
  logic [5:0] m_dec [K];
  logic       m_vld [K], m_err [K], m_busy [K], m_done [K];
  bit         m_known;

  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] act_dec(input int k);
    case (k)
      0:       return {2'b00, dec0};
      1:       return {2'b00, dec1};
      2:       return dec2;
      default: return {5'b00000, dec3};
    endcase
  endfunction

  task automatic cmp(input string name, input int k, input logic [5:0] act, input logic [5:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s dut%0d (W=%0d dir=%s) t=%0t: got %h expected %h",
               name, k, W[k], DN[k] ? "DOWN" : "UP", $time, act, expv);
    end
  endtask

  // One cycle: apply inputs, record expectations for this cycle, advance the model.
  task automatic drive(input bit r, input bit ss, input bit v, input logic [2:0] ix);
    exp_t e;
    int   ixk;
    @(posedge clk);
    #1;
    rst         = r;
    sweep_start = ss;
    index_valid = v;
    idx3        = ix;
    for (int k = 0; k < K; k++) begin
      e.chk  = m_known;
      e.dec  = m_dec[k];
      e.vld  = m_vld[k];
      e.err  = m_err[k];
      e.busy = m_busy[k];
      e.done = m_done[k];
      e.rdy  = (swp[k].size() == 0) && !ss;
      sbq[k].push_back(e);

      ixk = int'(ix) & ((1 << IWK[k]) - 1);
      m_dec[k] = '0; m_vld[k] = 0; m_err[k] = 0; m_busy[k] = 0; m_done[k] = 0;
      if (r) begin
        swp[k].delete();
      end else if (swp[k].size() > 0) begin
        void'(swp[k].pop_front());
        if (swp[k].size() > 0) begin
          m_dec[k]  = 6'(1) << swp[k][0];
          m_vld[k]  = 1;
          m_busy[k] = 1;
          m_done[k] = (swp[k].size() == 1);
        end
      end else if (ss) begin
        for (int i = 0; i < W[k]; i++) swp[k].push_back(DN[k] != 0 ? W[k] - 1 - i : i);
        m_dec[k]  = 6'(1) << swp[k][0];
        m_vld[k]  = 1;
        m_busy[k] = 1;
        m_done[k] = (W[k] == 1);
      end else if (v) begin
        if (ixk < W[k]) begin
          m_dec[k] = 6'(1) << ixk;
          m_vld[k] = 1;
        end else begin
          m_err[k] = 1;
        end
      end
    end
    if (r) m_known = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 3'd0);
  endtask

  // Monitor: every cycle each DUT presents its output; compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < K; k++) begin
        if (sbq[k].size() > 0) begin
          e = sbq[k].pop_front();
          if (e.chk) begin
            cmp("output_decoded", k, act_dec(k), e.dec);
            cmp("output_valid",   k, {5'b0, vld[k]}, {5'b0, e.vld});
            cmp("index_error",    k, {5'b0, err[k]}, {5'b0, e.err});
            cmp("busy",           k, {5'b0, bsy[k]}, {5'b0, e.busy});
            cmp("sweep_done",     k, {5'b0, dn[k]},  {5'b0, e.done});
            cmp("index_ready",    k, {5'b0, rdy[k]}, {5'b0, e.rdy});
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    bit         r, ss, v;
    logic [2:0] ix;
    vectors     = 0;
    miscompares = 0;
    m_known     = 0;
    rst         = 1;
    sweep_start = 0;
    index_valid = 0;
    idx3        = 0;
    for (int k = 0; k < K; k++) begin
      m_dec[k] = '0; m_vld[k] = 0; m_err[k] = 0; m_busy[k] = 0; m_done[k] = 0;
    end

    drive(1, 0, 0, 3'd0);
    drive(1, 0, 0, 3'd0);
    // Single decode then quiet
    drive(0, 0, 1, 3'd2);
    idle(2);
    // Back-to-back indices
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 3'(i));
    idle(1);
    // Out-of-range then in-range
    drive(0, 0, 1, 3'd7);
    drive(0, 0, 1, 3'd5);
    idle(2);
    // Full sweep
    drive(0, 1, 0, 3'd0);
    idle(8);
    // Sweep wins over a simultaneous index; index held until accepted
    drive(0, 1, 1, 3'd1);
    for (int i = 0; i < 7; i++) drive(0, 0, 1, 3'd1);
    idle(2);
    // Reset on the second sweep cycle
    drive(0, 1, 0, 3'd0);
    drive(0, 0, 0, 3'd0);
    drive(1, 0, 0, 3'd0);
    drive(0, 0, 1, 3'd3);
    idle(2);
    // Sweep request while busy is ignored
    drive(0, 1, 0, 3'd0);
    drive(0, 1, 0, 3'd0);
    drive(0, 1, 1, 3'd0);
    idle(8);

    for (int n = 0; n < 800; n++) begin
      r  = ($urandom_range(0, 99) < 2);
      ss = ($urandom_range(0, 99) < 8);
      v  = ($urandom_range(0, 99) < 60);
      ix = 3'($urandom_range(0, 7));
      drive(r, ss, v, ix);
    end
    idle(8);

    @(negedge clk);
    #1;
    for (int k = 0; k < K; k++) begin
      vectors++;
      if (sbq[k].size() != 0) begin
        miscompares++;
        $display("FAIL scoreboard_drain dut%0d: got %0d entries left, expected 0", k, sbq[k].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
